pipe_mux: RTL

PIPE_MUX -- requirements
Module: pipe_mux

---
 rtl/mux_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/pipe_mux.sv | 101 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for pipe_mux
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at ptr with wrap-around
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     grant_idx,
  output logic                found
);

  logic [2*CHANNELS-1:0] req_dbl;
  logic [CHANNELS-1:0]   req_rot;
  int                    offset;
  int                    idx;

  // Rotating a doubled copy puts channel ptr at bit 0, so a plain
  // lowest-set-bit search yields the wrap-around order.
  always_comb begin
    req_dbl   = {req, req} >> ptr;
    req_rot   = req_dbl[CHANNELS-1:0];
    found     = 1'b0;
    offset    = 0;
    idx       = 0;
    grant_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    idx = int'(ptr) + offset;
    if (idx >= CHANNELS) begin
      idx = idx - CHANNELS;
    end
    grant_idx = SELW'(idx);
  end

endmodule

// File: rtl/pipe_mux.sv
// rtl/pipe_mux.sv - N-channel to one mux with single-entry output register
module pipe_mux #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);

  import mux_pkg::*;

  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic [SELW-1:0]           out_chan_q, out_chan_d;
  logic [SELW-1:0]           ptr_q, ptr_d;

  logic [SELW-1:0]           arb_idx;
  logic                      arb_found;
  logic [SELW-1:0]           g;
  logic                      grant_ok;
  logic                      slot_free;
  logic                      capture;
  logic [CHANNELS-1:0]       valid_shift;
  logic [CHANNELS*WIDTH-1:0] data_shift;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_idx (arb_idx),
    .found     (arb_found)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    if (mode == MODE_RR) begin
      g        = arb_idx;
      grant_ok = arb_found;
    end else begin
      g        = sel;
      grant_ok = (int'(sel) < CHANNELS);
    end

    valid_shift = in_valid >> g;
    data_shift  = in_data >> (int'(g) * WIDTH);

    // Ready reflects only grant and slot availability, never the channel's valid.
    in_ready = '0;
    if (rst_n && enable && slot_free && grant_ok) begin
      in_ready = CHANNELS'(1) << g;
    end
    capture = rst_n && enable && slot_free && grant_ok && valid_shift[0];

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (capture) begin
      out_data_d  = data_shift[WIDTH-1:0];
      out_valid_d = 1'b1;
      out_chan_d  = g;
      if (mode == MODE_RR) begin
        ptr_d = (int'(g) == CHANNELS - 1) ? '0 : g + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule
